// File: rtl/host_word_loader.sv
// Host word entry stage: normalises keypad ASCII, assembles the secret word,
// supports backspace, and hands the finished word to the game logic.
module host_word_loader #(
    parameter int WORD_LEN = 5
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic [7:0]            key_data,
    input  logic                  key_valid,
    input  logic                  key_del,
    input  logic                  key_submit,
    input  logic                  game_rdy,
    input  logic                  new_game,
    output logic [WORD_LEN*8-1:0] setWord,
    output logic                  toggle_state,
    output logic [2:0]            letter_count,
    output logic [7:0]            last_letter,
    output logic                  word_locked,
    output logic                  bad_key
);

    localparam int WORD_W = WORD_LEN * 8;

    typedef enum logic [1:0] {
        ENTRY,
        FULL,
        LOCKED
    } state_t;

    state_t     state;
    logic       norm_ok;
    logic [7:0] norm_letter;

    // Uppercase passes through, lowercase is folded to uppercase, all else rejected.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        norm_ok     = 1'b0;
        norm_letter = 8'h00;
        if (key_data >= 8'h41 && key_data <= 8'h5A) begin
            norm_ok     = 1'b1;
            norm_letter = key_data;
        end else if (key_data >= 8'h61 && key_data <= 8'h7A) begin
            norm_ok     = 1'b1;
            norm_letter = key_data - 8'h20;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state        <= ENTRY;
            setWord      <= '0;
            letter_count <= 3'd0;
            last_letter  <= 8'h00;
            toggle_state <= 1'b0;
            word_locked  <= 1'b0;
            bad_key      <= 1'b0;
        end else begin
            toggle_state <= 1'b0;
            bad_key      <= 1'b0;

            // Strobe priority: new_game > key_del > key_submit > key_valid.
            if (new_game) begin
                if (state == LOCKED) begin
                    state        <= ENTRY;
                    setWord      <= '0;
                    letter_count <= 3'd0;
                    last_letter  <= 8'h00;
                    word_locked  <= 1'b0;
                end
            end else if (key_del) begin
                if (state == FULL || (state == ENTRY && letter_count != 3'd0)) begin
                    setWord      <= {8'h00, setWord[WORD_W-1:8]};
                    letter_count <= letter_count - 3'd1;
                    last_letter  <= (letter_count == 3'd1) ? 8'h00 : setWord[15:8];
                    state        <= ENTRY;
                end
            end else if (key_submit) begin
                if (state == FULL && game_rdy) begin
                    state        <= LOCKED;
                    toggle_state <= 1'b1;
                    word_locked  <= 1'b1;
                end else if (state != LOCKED) begin
                    bad_key <= 1'b1;
                end
            end else if (key_valid) begin
                if (state == ENTRY && norm_ok) begin
                    setWord      <= {setWord[WORD_W-9:0], norm_letter};
                    letter_count <= letter_count + 3'd1;
                    last_letter  <= norm_letter;
                    if (letter_count == 3'(WORD_LEN - 1))
                        state <= FULL;
                end else if (state != LOCKED) begin
                    bad_key <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/host_word_loader.md
# host_word_loader

Host-side word entry stage sitting directly upstream of the game logic block. Accepts ASCII keystrokes from the host keypad decoder, normalises and validates them, and assembles the 5-letter secret word into a 40-bit register. Supports backspace, holds the word for the whole game, and issues the one-cycle `toggle_state` pulse that moves the game logic out of its SET state. Only a complete word that the game logic reports ready for can be submitted.

## Interface
- `WORD_LEN`, 5: letters per word; fixed, fed to a 40-bit output.
- `clk`  in  1  system clock, all logic on rising edge
- `nRst`  in  1  asynchronous active-low reset
- `key_data`  in  8  ASCII code, valid only with `key_valid`
- `key_valid`  in  1  one-cycle strobe: enter `key_data`
- `key_del`  in  1  one-cycle strobe: remove last letter
- `key_submit`  in  1  one-cycle strobe: confirm word
- `game_rdy`  in  1  game logic ready for a new word
- `new_game`  in  1  one-cycle strobe: unlock and clear for the next round
- `setWord`  out  40  word; first letter in [39:32], last in [7:0]
- `toggle_state`  out  1  one-cycle start pulse to game logic
- `letter_count`  out  3  letters held, 0..5
- `last_letter`  out  8  most recently accepted letter, 0 if none
- `word_locked`  out  1  high while in LOCKED
- `bad_key`  out  1  one-cycle error pulse

## Operation
- States: ENTRY, FULL, LOCKED. Reset state ENTRY.
- Normalisation: 0x41–0x5A accepted as-is. 0x61–0x7A has 0x20 subtracted. Any other code is rejected.
- Accepted letter in ENTRY:
  - `setWord <= {setWord[31:0], letter}` and `letter_count` +1.
  - `last_letter <= letter`.
  - On count reaching 5, go to FULL.
- Rejected code, or `key_valid` in FULL: `bad_key` pulses, and word and count are unchanged.
- `key_del` in ENTRY with count>0, or in FULL:
  - `setWord <= {8'h00, setWord[39:8]}` and count -1.
  - `last_letter <=` the new `setWord[7:0]` after the shift, or 0 if the count becomes 0.
  - FULL returns to ENTRY.
- `key_del` with count==0: no effect, no `bad_key`.
- `key_submit` in FULL with `game_rdy`=1: go to LOCKED and pulse `toggle_state`.
- `key_submit` in ENTRY, or in FULL with `game_rdy`=0: `bad_key` pulses and the state is unchanged.
- LOCKED:
  - `key_valid`, `key_del` and `key_submit` are ignored silently.
  - `setWord` is frozen.
  - `new_game` clears `setWord`, count and `last_letter` to 0 and returns to ENTRY.
  - `new_game` outside LOCKED has no effect.
- Simultaneous strobes: priority `new_game` > `key_del` > `key_submit` > `key_valid`. Only the winner acts; losers are dropped with no `bad_key`.
- Width rules: count is saturating 0..5 and never wraps. The word is never partially written: a shift occurs only on an accepted letter or a delete.

## Timing
- All outputs registered. Every effect is visible the cycle after the strobe's sampling edge.
- `toggle_state` and `bad_key` are high for exactly one cycle per event. Back-to-back strobes give back-to-back pulses.
- `word_locked` rises in the same cycle as `toggle_state` and falls the cycle after `new_game` is sampled.
- Reset values: `setWord`=0, `letter_count`=0, `last_letter`=0, `toggle_state`=0, `word_locked`=0, `bad_key`=0, state ENTRY.
- Reset mid-entry or mid-game clears everything immediately, asynchronously, with no pulse emitted.
- `game_rdy` is sampled only on the `key_submit` cycle and is not held pending.

## Test plan
- **Basic entry and submit.** Reset, key "H","E","L","L","O" (0x48,0x45,0x4C,0x4C,0x4F), then submit with `game_rdy`=1.
  - `setWord`=0x48454C4C4F and count 5.
  - One `toggle_state` pulse; `word_locked`=1.
- **Lowercase, bad keys, early submit.** Key "a",'3',"b", then submit.
  - `setWord`=0x0000004142 and count 2.
  - `bad_key` pulses twice: once for '3', once for the early submit.
  - No `toggle_state`.
- **Backspace.** Enter "ABCDE", delete, key 'Z'.
  - After the delete: count 4, state ENTRY, `last_letter`=0x44.
  - After 'Z': `setWord`=0x414243445A and state FULL.
  - Delete at count 0 gives no change and no `bad_key`.
- **Full and not-ready.** In FULL, key 'Q' gives `bad_key` and an unchanged word. Submit with `game_rdy`=0 gives `bad_key`, no `toggle_state`, state still FULL.
- **Simultaneous strobes.** In FULL, assert `key_del`+`key_submit`+`key_valid` in one cycle.
  - Only the delete acts: count 4.
  - No `toggle_state`, no `bad_key`.
- **Lock and reset.** In LOCKED, keys are ignored and `setWord` is stable. Then:
  - `new_game` clears all to 0 next cycle and returns to ENTRY.
  - Asserting `nRst` low mid-entry zeroes all outputs asynchronously.
